filter_window_3x3: RTL and testbench
====================================

FILTER_WINDOW_3X3 -- requirements
Module: filter_window_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 64, meaning pixels per line; legal range 3..1024.
REQ-002 Parameter IMG_HEIGHT, default 64, meaning lines per frame; legal range 3..1024.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_pixel/in_sof carry a pixel this cycle.
REQ-006 in_ready  output  1  block can accept a pixel this cycle.
REQ-007 in_pixel  input  8  unsigned pixel, raster order, left to right, top to bottom.
REQ-008 in_sof  input  1  qualifies in_pixel as the first pixel of a frame.
REQ-009 out_valid  output  1  window_out holds a valid 3x3 window.
REQ-010 out_ready  input  1  downstream median filter accepts the window.
REQ-011 window_out  output  72  3x3 window; row i (0=top), column j (0=left) at bits [i*24+j*8 +: 8].
REQ-012 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-013 Pixel accepted when in_valid && in_ready; in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-014 Column counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1 SHALL advance per accepted pixel; column wraps to 0 and row increments; row wraps to 0 after the last column of the last row.
REQ-015 Accepted pixel with in_sof=1 SHALL be treated as (row 0, col 0) regardless of counter state; earlier partial-frame data is discarded and no window from it is emitted afterwards.
REQ-016 Two line buffers (IMG_WIDTH x 8 each) SHALL hold the previous two lines, addressed by column counter, read-before-write per accepted pixel.
REQ-017 A 3x3 shift window SHALL shift left one column per accepted pixel, loading new right column {line2[col], line1[col], in_pixel} as rows {0,1,2}.
REQ-018 Window emitted only for interior centers: accepted pixel at row>=2 and col>=2 produces the window centered on (row-1, col-1); (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-019 Latency: window_out/out_valid SHALL be registered and asserted the cycle after the producing pixel is accepted.
REQ-020 out_valid SHALL stay high and window_out SHALL stay stable until out_ready=1; transfer clears out_valid unless a new window is produced in the same cycle (then out_valid remains 1 with new data).
REQ-021 Pixels at col<2 or row<2 update line buffers and window but SHALL NOT assert out_valid.
REQ-022 frame_done SHALL pulse for one cycle on acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1); not pulsed when in_sof truncates a frame.
REQ-023 in_valid without in_ready SHALL change no state.

Reset
REQ-024 On rst high: out_valid=0, window_out=0, frame_done=0, counters=0, window registers=0, asynchronously.
REQ-025 in_ready SHALL be 1 during and after reset; line buffer contents need not be cleared (never emitted before overwritten).
REQ-026 Reset mid-frame SHALL drop any pending window; next accepted pixel is (0,0) even without in_sof.

Structure
REQ-027 Shared package holds PIXEL_W=8, WIN_SIZE=3, WIN_W=72 and the window bit-index convention shared with the median filter.
REQ-028 One sub-module: filter_line_buffer (single-port IMG_WIDTH x 8 read-before-write memory), instantiated twice.
REQ-029 Output registers and counters live in filter_window_3x3; no other hierarchy.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, out_ready=1 unless stated)
REQ-030 Ramp 0..15, in_sof on pixel 0 -> first out_valid cycle after pixel 10; window_out bytes (byte0..8) = 0,1,2,4,5,6,8,9,10.
REQ-031 Same ramp -> exactly 4 windows, last = 5,6,7,9,10,11,13,14,15; frame_done pulses once, cycle after pixel 15 accepted.
REQ-032 out_ready=0 from pixel 10 for 5 cycles, in_valid=1 -> in_ready=0, window_out held at 0..10 window, no pixel lost; resuming yields the same 4 windows.
REQ-033 rst asserted after pixel 9, then ramp restarted without in_sof -> out_valid=0 during reset; first window after restart equals REQ-030.
REQ-034 in_sof asserted on pixel 6 of a frame, followed by ramp 100..115 -> no frame_done for truncated frame; first window = 100,101,102,104,105,106,108,109,110.

Source files
------------

// File: rtl/filter_window_3x3_pkg.sv
// Shared pixel/window types and the window bit-index convention used by the
// window generator and the downstream median filter.
package filter_window_3x3_pkg;

    localparam int PIXEL_W  = 8;
    localparam int WIN_SIZE = 3;
    localparam int WIN_W    = PIXEL_W * WIN_SIZE * WIN_SIZE;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0]   window_t;

    // Row 0 is the top row, column 0 the left column.
    function automatic int win_bit(input int row, input int col);
        return row * WIN_SIZE * PIXEL_W + col * PIXEL_W;
    endfunction

endpackage

// File: rtl/filter_window_3x3_if.sv
// Pixel stream in, 3x3 window stream out, plus frame completion pulse.
// master = pixel source / window sink, slave = window generator.
interface filter_window_3x3_if;
    import filter_window_3x3_pkg::*;

    logic    in_valid;
    logic    in_ready;
    pixel_t  in_pixel;
    logic    in_sof;
    logic    out_valid;
    logic    out_ready;
    window_t window_out;
    logic    frame_done;

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, window_out, frame_done
    );

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, window_out, frame_done
    );

endinterface

// File: rtl/filter_line_buffer.sv
// Single-port line memory: combinational read of the addressed entry, write on
// the clock edge, so a same-cycle read returns the old contents. No backpressure.
module filter_line_buffer
    import filter_window_3x3_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  pixel_t        wr_dat,
    output pixel_t        rd_dat
);

    pixel_t mem [DEPTH];

    assign rd_dat = mem[addr];

    // Contents are never reset: every entry is rewritten before it can reach
    // an emitted window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/filter_window_3x3.sv
// Builds 3x3 windows from a raster pixel stream; window registered 1 cycle after the
// interior pixel is accepted; input stalls only while an unaccepted window is held.
module filter_window_3x3
    import filter_window_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic clk,
    input  logic rst,
    filter_window_3x3_if.slave bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef logic [CW-1:0] col_t;
    typedef logic [RW-1:0] row_t;

    localparam col_t COL_LAST = col_t'(IMG_WIDTH - 1);
    localparam row_t ROW_LAST = row_t'(IMG_HEIGHT - 1);

    col_t    col_q;
    row_t    row_q;
    col_t    col_eff;
    row_t    row_eff;
    logic    accept;
    logic    emit;
    logic    last_pix;
    logic    out_valid_q;
    logic    frame_done_q;
    window_t window_q;
    window_t win_flat;
    pixel_t  line1_rd;
    pixel_t  line2_rd;
    pixel_t  win_q [WIN_SIZE][WIN_SIZE];
    pixel_t  win_d [WIN_SIZE][WIN_SIZE];

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.window_out = window_q;
    assign bus.frame_done = frame_done_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Start-of-frame forces position (0,0) whatever the counters say.
    assign col_eff  = bus.in_sof ? '0 : col_q;
    assign row_eff  = bus.in_sof ? '0 : row_q;
    assign emit     = (row_eff >= row_t'(2)) && (col_eff >= col_t'(2));
    assign last_pix = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

    // line1 holds the previous line, line2 the one above it; the old line1
    // entry migrates into line2 as the new pixel overwrites it.
    filter_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_line1 (
        .clk    (clk),
        .addr   (col_eff),
        .wr_en  (accept),
        .wr_dat (bus.in_pixel),
        .rd_dat (line1_rd)
    );

    filter_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_line2 (
        .clk    (clk),
        .addr   (col_eff),
        .wr_en  (accept),
        .wr_dat (line1_rd),
        .rd_dat (line2_rd)
    );

    always_comb begin
        win_d = win_q;
        for (int i = 0; i < WIN_SIZE; i++) begin
            for (int j = 0; j < WIN_SIZE - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
        end
        win_d[0][WIN_SIZE-1] = line2_rd;
        win_d[1][WIN_SIZE-1] = line1_rd;
        win_d[2][WIN_SIZE-1] = bus.in_pixel;
    end

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < WIN_SIZE; i++) begin
            for (int j = 0; j < WIN_SIZE; j++) begin
                win_flat[win_bit(i, j) +: PIXEL_W] = win_d[i][j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            window_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && last_pix;
            if (accept) begin
                win_q <= win_d;
                if (col_eff == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_eff == ROW_LAST) ? '0 : row_eff + row_t'(1);
                end else begin
                    col_q <= col_eff + col_t'(1);
                    row_q <= row_eff;
                end
            end
            // A fresh window may replace one being transferred this cycle.
            if (accept && emit) begin
                out_valid_q <= 1'b1;
                window_q    <= win_flat;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_window_3x3.sv
// Directed test of filter_window_3x3 on a 4x4 image.
module tb_filter_window_3x3;
    import filter_window_3x3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   fd_cnt = 0;
    window_t got [$];

    filter_window_3x3_if bus ();

    filter_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so a negedge view of
    // out_valid && out_ready is exactly the transfer at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.window_out);
            if (bus.frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window centred on (r,c) of a 4-wide ramp starting at base.
    function automatic window_t exp_win(input int base, input int r, input int c);
        window_t w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = 8'(base + (r - 1 + i) * 4 + (c - 1 + j));
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send pixel base+idx of a ramp frame and check the registered result.
    task automatic send_chk(input int base, input int idx, input bit sof);
        bit acc = 1'b0;
        int r = idx / 4;
        int c = idx % 4;
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'(base + idx);
        bus.in_sof   = sof;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        chk($sformatf("accept_%0d", base + idx), acc, 1);
        chk($sformatf("out_valid_%0d", base + idx), bus.out_valid, (r >= 2 && c >= 2));
        if (r >= 2 && c >= 2)
            chk($sformatf("window_%0d", base + idx), bus.window_out, exp_win(base, r - 1, c - 1));
        chk($sformatf("frame_done_%0d", base + idx), bus.frame_done, (idx == 15));
    endtask

    task automatic chk_windows(input string tag, input int base);
        chk({tag, "_count"}, got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("%s_win%0d", tag, k), got[k], exp_win(base, 1 + k / 2, 1 + k % 2));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_window", bus.window_out, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Plain ramp frame.
        got.delete();
        fd_cnt = 0;
        for (int i = 0; i < 16; i++) send_chk(0, i, i == 0);
        step();
        chk("ramp_frame_done_clear", bus.frame_done, 0);
        chk_windows("ramp", 0);
        chk("ramp_fd_cnt", fd_cnt, 1);

        // Downstream stall right after the first window.
        got.delete();
        fd_cnt = 0;
        for (int i = 0; i < 10; i++) send_chk(0, i, i == 0);
        bus.out_ready = 1'b0;
        send_chk(0, 10, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'd11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_in_ready_%0d", k), bus.in_ready, 0);
            chk($sformatf("stall_out_valid_%0d", k), bus.out_valid, 1);
            chk($sformatf("stall_window_%0d", k), bus.window_out, exp_win(0, 1, 1));
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 11; i < 16; i++) send_chk(0, i, 1'b0);
        step();
        chk_windows("stall", 0);
        chk("stall_fd_cnt", fd_cnt, 1);

        // Reset mid-frame, restart without start-of-frame.
        for (int i = 0; i < 10; i++) send_chk(0, i, i == 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_window", bus.window_out, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        step();
        chk("midrst_out_valid_hold", bus.out_valid, 0);
        rst = 1'b0;
        got.delete();
        fd_cnt = 0;
        for (int i = 0; i < 16; i++) send_chk(0, i, 1'b0);
        step();
        chk_windows("restart", 0);
        chk("restart_fd_cnt", fd_cnt, 1);

        // Frame truncated by start-of-frame at its seventh pixel.
        got.delete();
        fd_cnt = 0;
        for (int i = 0; i < 6; i++) send_chk(0, i, i == 0);
        for (int i = 0; i < 16; i++) send_chk(100, i, i == 0);
        step();
        chk_windows("trunc", 100);
        chk("trunc_fd_cnt", fd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
